// File: rtl/trng_pkg.sv
`default_nettype none
// ============================================================================
// Module : trng_pkg
// Brief  : Shared constants, FSM encoding and popcount helper for the TRNG
//          health-test FIFO.
// Rev    : 1.0
// ============================================================================
package trng_pkg;

    localparam int c_word_w        = 32;
    localparam int c_def_depth     = 16;
    localparam int c_def_warmup    = 8;
    localparam int c_def_rep_limit = 4;
    localparam int c_def_win_words = 32;
    localparam int c_def_ones_lo   = 460;
    localparam int c_def_ones_hi   = 564;

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_RUN    = 2'd1,
        ST_FAIL   = 2'd2
    } state_t;

    function automatic logic [5:0] popcount32(input logic [c_word_w-1:0] w);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < c_word_w; i++) begin
            n = n + {5'd0, w[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/trng_word_fifo.sv
`default_nettype none
// ============================================================================
// Module : trng_word_fifo
// Brief  : First-word-fall-through synchronous FIFO with flush.
// Rev    : 1.0
// ============================================================================
module trng_word_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int c_ptr_w = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_level;
    logic               w_pop;
    logic               w_push;

    assign empty = (r_level == '0);
    assign full  = (r_level == (c_ptr_w+1)'(DEPTH));
    assign level = r_level;
    // Pop while empty is ignored; a full FIFO still accepts a push paired with a pop.
    assign w_pop  = pop & ~empty & ~flush;
    assign w_push = push & (~full | w_pop) & ~flush;
    assign dout   = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (c_ptr_w+1)'(1);
                2'b01:   r_level <= r_level - (c_ptr_w+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/trng_health_fifo.sv
`default_nettype none
// ============================================================================
// Module : trng_health_fifo
// Brief  : TRNG warm-up discard, repetition/ones-density health tests and
//          output buffering with sticky alarms.
// Rev    : 1.0
// ============================================================================
module trng_health_fifo
    import trng_pkg::*;
#(
    parameter int DEPTH     = c_def_depth,
    parameter int WARMUP    = c_def_warmup,
    parameter int REP_LIMIT = c_def_rep_limit,
    parameter int WIN_WORDS = c_def_win_words,
    parameter int ONES_LO   = c_def_ones_lo,
    parameter int ONES_HI   = c_def_ones_hi
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [c_word_w-1:0]     in_data,
    input  logic                    in_valid,
    output logic [c_word_w-1:0]     m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow,
    output logic                    health_fail,
    input  logic                    clear_err
);

    localparam int c_warm_w = $clog2(WARMUP + 1);
    localparam int c_rep_w  = $clog2(REP_LIMIT + 1);
    localparam int c_acc_w  = $clog2(c_word_w * WIN_WORDS + 1);
    localparam int c_win_w  = $clog2(WIN_WORDS + 1);

    localparam logic [c_warm_w-1:0] c_warm_last = c_warm_w'(WARMUP - 1);
    localparam logic [c_rep_w-1:0]  c_rep_limit = c_rep_w'(REP_LIMIT);
    localparam logic [c_win_w-1:0]  c_win_last  = c_win_w'(WIN_WORDS - 1);
    localparam logic [c_acc_w-1:0]  c_ones_lo   = c_acc_w'(ONES_LO);
    localparam logic [c_acc_w-1:0]  c_ones_hi   = c_acc_w'(ONES_HI);

    state_t                r_state;
    logic [c_warm_w-1:0]   r_warm_cnt;
    logic [c_rep_w-1:0]    r_rep_cnt;
    logic [c_word_w-1:0]   r_last_word;
    logic [c_acc_w-1:0]    r_acc;
    logic [c_win_w-1:0]    r_win_cnt;
    logic                  r_overflow;
    logic                  r_health_fail;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop_now;
    logic                  w_run_word;
    logic [c_rep_w-1:0]    w_rep_next;
    logic [c_acc_w-1:0]    w_sum;
    logic                  w_win_last;
    logic                  w_fail;
    logic                  w_push;
    logic                  w_drop;

    assign m_valid     = ~w_empty;
    assign overflow    = r_overflow;
    assign health_fail = r_health_fail;

    assign w_pop_now  = m_valid & m_ready;
    assign w_run_word = in_valid & (r_state == ST_RUN) & ~clear_err;
    // A zero count marks the first word after warm-up, which never matches.
    assign w_rep_next = ((r_rep_cnt != '0) && (in_data == r_last_word))
                        ? r_rep_cnt + c_rep_w'(1) : c_rep_w'(1);
    assign w_sum      = r_acc + c_acc_w'(popcount32(in_data));
    assign w_win_last = (r_win_cnt == c_win_last);
    assign w_fail     = (w_rep_next >= c_rep_limit) |
                        (w_win_last & ((w_sum < c_ones_lo) | (w_sum > c_ones_hi)));
    assign w_push     = w_run_word & ~w_fail & (~w_full | w_pop_now);
    assign w_drop     = w_run_word & ~w_fail & w_full & ~w_pop_now;

    trng_word_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_word_w)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (m_ready),
        .flush (clear_err),
        .din   (in_data),
        .dout  (m_data),
        .empty (w_empty),
        .full  (w_full),
        .level (level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_WARMUP;
            r_warm_cnt    <= '0;
            r_rep_cnt     <= '0;
            r_last_word   <= '0;
            r_acc         <= '0;
            r_win_cnt     <= '0;
            r_overflow    <= 1'b0;
            r_health_fail <= 1'b0;
        end else if (clear_err) begin
            r_state       <= ST_WARMUP;
            r_warm_cnt    <= '0;
            r_rep_cnt     <= '0;
            r_last_word   <= '0;
            r_acc         <= '0;
            r_win_cnt     <= '0;
            r_overflow    <= 1'b0;
            r_health_fail <= 1'b0;
        end else begin
            case (r_state)
                ST_WARMUP: begin
                    if (in_valid) begin
                        if (r_warm_cnt == c_warm_last) begin
                            r_state    <= ST_RUN;
                            r_warm_cnt <= '0;
                            r_rep_cnt  <= '0;
                            r_acc      <= '0;
                            r_win_cnt  <= '0;
                        end else begin
                            r_warm_cnt <= r_warm_cnt + c_warm_w'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (in_valid) begin
                        r_rep_cnt   <= w_rep_next;
                        r_last_word <= in_data;
                        if (w_win_last) begin
                            r_acc     <= '0;
                            r_win_cnt <= '0;
                        end else begin
                            r_acc     <= w_sum;
                            r_win_cnt <= r_win_cnt + c_win_w'(1);
                        end
                        if (w_fail) begin
                            r_state       <= ST_FAIL;
                            r_health_fail <= 1'b1;
                        end
                        if (w_drop) begin
                            r_overflow <= 1'b1;
                        end
                    end
                end
                ST_FAIL: begin
                    r_state <= ST_FAIL;
                end
                default: begin
                    r_state <= ST_WARMUP;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_trng_health_fifo.sv
`default_nettype none
// ============================================================================
// Module : tb_trng_health_fifo
// Brief  : Directed bench with a queue-based reference model for trng_health_fifo.
// Rev    : 1.0
// ============================================================================
module tb_trng_health_fifo;

    localparam int DEPTH     = 16;
    localparam int WARMUP    = 8;
    localparam int REP_LIMIT = 4;
    localparam int WIN_WORDS = 32;
    localparam int ONES_LO   = 460;
    localparam int ONES_HI   = 564;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [4:0]  level;
    logic        overflow;
    logic        health_fail;
    logic        clear_err = 1'b0;

    int checks   = 0;
    int failures = 0;
    bit run_cmp  = 1'b0;

    always #5 clk = ~clk;

    trng_health_fifo #(
        .DEPTH(DEPTH), .WARMUP(WARMUP), .REP_LIMIT(REP_LIMIT),
        .WIN_WORDS(WIN_WORDS), .ONES_LO(ONES_LO), .ONES_HI(ONES_HI)
    ) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .level(level),
        .overflow(overflow), .health_fail(health_fail), .clear_err(clear_err)
    );

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: 0=warm-up, 1=run, 2=fail; words held in a plain queue.
    logic [31:0] mq[$];
    int          m_st, m_warm, m_rep, m_acc, m_win;
    logic [31:0] m_last;
    bit          m_ovf, m_hf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_st = 0; m_warm = 0; m_rep = 0; m_acc = 0; m_win = 0;
            m_last = '0; m_ovf = 0; m_hf = 0;
        end else if (clear_err) begin
            mq.delete();
            m_st = 0; m_warm = 0; m_rep = 0; m_acc = 0; m_win = 0;
            m_last = '0; m_ovf = 0; m_hf = 0;
        end else begin
            bit pop, push, fail;
            int sum;
            pop  = (mq.size() != 0) && m_ready;
            push = 0;
            fail = 0;
            if (in_valid) begin
                if (m_st == 0) begin
                    m_warm++;
                    if (m_warm == WARMUP) begin
                        m_st = 1; m_warm = 0; m_rep = 0; m_acc = 0; m_win = 0;
                    end
                end else if (m_st == 1) begin
                    m_rep  = (m_rep != 0 && in_data == m_last) ? m_rep + 1 : 1;
                    m_last = in_data;
                    if (m_rep >= REP_LIMIT) fail = 1;
                    sum = m_acc + $countones(in_data);
                    m_win++;
                    if (m_win == WIN_WORDS) begin
                        if (sum < ONES_LO || sum > ONES_HI) fail = 1;
                        m_acc = 0; m_win = 0;
                    end else begin
                        m_acc = sum;
                    end
                    if (fail) begin
                        m_st = 2; m_hf = 1;
                    end else if (mq.size() < DEPTH || pop) begin
                        push = 1;
                    end else begin
                        m_ovf = 1;
                    end
                end
            end
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back(in_data);
        end
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            chk("m_valid", 64'(m_valid), 64'(mq.size() != 0));
            chk("level", 64'(level), 64'(mq.size()));
            if (mq.size() != 0) chk("m_data", 64'(m_data), 64'(mq[0]));
            chk("overflow", 64'(overflow), 64'(m_ovf));
            chk("health_fail", 64'(health_fail), 64'(m_hf));
        end
    end

    task automatic cyc(input bit v, input logic [31:0] d, input bit r, input bit c);
        in_valid  = v;
        in_data   = d;
        m_ready   = r;
        clear_err = c;
        @(negedge clk);
        in_valid  = 1'b0;
        clear_err = 1'b0;
    endtask

    task automatic warmup();
        for (int i = 0; i < WARMUP; i++) cyc(1'b1, 32'h0F0F0000 + 32'(i), 1'b0, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_health_fail", 64'(health_fail), 64'd0);
        run_cmp = 1'b1;

        // Warm-up discard, then first passing word with one-cycle latency.
        warmup();
        chk("warm_m_valid", 64'(m_valid), 64'd0);
        cyc(1'b1, 32'hAAAAAAAA, 1'b0, 1'b0);
        chk("first_level", 64'(level), 64'd1);
        chk("first_data", 64'(m_data), 64'hAAAAAAAA);

        // Restart and stream one full window of balanced words.
        cyc(1'b0, '0, 1'b0, 1'b1);
        warmup();
        for (int i = 0; i < 32; i++)
            cyc(1'b1, (i % 2 == 0) ? 32'hAAAAAAAA : 32'h55555555, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("thru_level", 64'(level), 64'd0);
        chk("thru_hf", 64'(health_fail), 64'd0);

        // Repetition failure on the fourth identical word.
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h12345678, 1'b0, 1'b0);
        chk("rep_hf", 64'(health_fail), 64'd1);
        chk("rep_level", 64'(level), 64'd3);
        cyc(1'b1, 32'h0000FFFF, 1'b0, 1'b0);
        chk("fail_level_hold", 64'(level), 64'd3);

        // Clear wins over same-cycle word and pop.
        cyc(1'b1, 32'h0000FFFF, 1'b1, 1'b1);
        chk("clr_level", 64'(level), 64'd0);
        chk("clr_hf", 64'(health_fail), 64'd0);
        chk("clr_m_valid", 64'(m_valid), 64'd0);

        // Ones-density window failure (sum 1008).
        warmup();
        for (int i = 0; i < 32; i++)
            cyc(1'b1, (i % 2 == 0) ? 32'hFFFFFFFF : 32'hFFFFFFFE, 1'b1, 1'b0);
        chk("ones_hf", 64'(health_fail), 64'd1);
        chk("ones_level", 64'(level), 64'd0);

        // Overflow with a stalled consumer, then push+pop at full.
        cyc(1'b0, '0, 1'b0, 1'b1);
        warmup();
        for (int i = 0; i < 17; i++) cyc(1'b1, 32'hA5A50000 | 32'(i), 1'b0, 1'b0);
        chk("ovf_level", 64'(level), 64'd16);
        chk("ovf_flag", 64'(overflow), 64'd1);
        cyc(1'b1, 32'h5A5A0001, 1'b1, 1'b0);
        chk("ovf_pp_level", 64'(level), 64'd16);
        chk("ovf_pp_head", 64'(m_data), 64'hA5A50001);
        for (int i = 0; i < 16; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        chk("drain_level", 64'(level), 64'd0);

        // Asynchronous reset between clock edges.
        cyc(1'b1, 32'h3C3C3C3C, 1'b0, 1'b0);
        cyc(1'b1, 32'hC3C3C3C3, 1'b0, 1'b0);
        chk("pre_rst_level", 64'(level), 64'd2);
        #2 rst = 1'b1;
        #1;
        chk("arst_level", 64'(level), 64'd0);
        chk("arst_m_valid", 64'(m_valid), 64'd0);
        chk("arst_m_data", 64'(m_data), 64'd0);
        chk("arst_overflow", 64'(overflow), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
